// File: rtl/lfsr8_sched.sv
// Shares one 8-bit Fibonacci LFSR between two requesters: round-robin grant,
// N steps per grant, result byte returned with a one-cycle done pulse.
module lfsr8_sched #(
    parameter logic [7:0] SEED_INIT = 8'h01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       seed_we,
    input  logic [7:0] seed,
    output logic       seed_err,
    input  logic       req0,
    input  logic [3:0] steps0,
    input  logic       req1,
    input  logic [3:0] steps1,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       done,
    output logic [7:0] dout
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic        last_q, last_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  dout_q, dout_d;
    logic        seed_err_q, seed_err_d;
    logic        win1;
    logic [3:0]  win_steps;

    // Byte is {q1..q8}, so q_k sits at bit 8-k; taps q8,q6,q5,q3 -> bits 0,2,3,5.
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        logic fb;
        fb = v[0] ^ v[2] ^ v[3] ^ v[5];
        return {fb, v[7:1]};
    endfunction

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        cnt_d      = cnt_q;
        dout_d     = dout_q;
        seed_err_d = 1'b0;
        // On a tie the requester that was not served last wins.
        win1       = (req0 && req1) ? ~last_q : req1;
        win_steps  = win1 ? steps1 : steps0;

        case (state_q)
            IDLE: begin
                if (seed_we) begin
                    lfsr_d = (seed == 8'h00) ? SEED_INIT : seed;
                end else if (req0 || req1) begin
                    gnt_d   = win1 ? 2'b10 : 2'b01;
                    cnt_d   = (win_steps == 4'd0) ? 5'd16 : {1'b0, win_steps};
                    state_d = RUN;
                end
            end
            RUN: begin
                seed_err_d = seed_we;
                lfsr_d     = lfsr_step(lfsr_q);
                cnt_d      = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    dout_d  = lfsr_d;
                    state_d = DONE;
                end
            end
            DONE: begin
                seed_err_d = seed_we;
                last_d     = gnt_q[1];
                gnt_d      = 2'b00;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lfsr_q     <= SEED_INIT;
            last_q     <= 1'b1;
            gnt_q      <= 2'b00;
            cnt_q      <= 5'd0;
            dout_q     <= 8'h00;
            seed_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            seed_err_q <= seed_err_d;
        end
    end

    assign gnt      = gnt_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign dout     = dout_q;
    assign seed_err = seed_err_q;

endmodule

// File: tb/tb_lfsr8_sched.sv
// Bench for lfsr8_sched: table of single services plus tie, abort and 16-step sequences.
module tb_lfsr8_sched;

    logic       clk = 1'b0;
    logic       rst, seed_we, req0, req1;
    logic [7:0] seed;
    logic [3:0] steps0, steps1;
    logic       seed_err, busy, done;
    logic [1:0] gnt;
    logic [7:0] dout;

    lfsr8_sched #(.SEED_INIT(8'h01)) dut (
        .clk(clk), .rst(rst), .seed_we(seed_we), .seed(seed), .seed_err(seed_err),
        .req0(req0), .steps0(steps0), .req1(req1), .steps1(steps1),
        .gnt(gnt), .busy(busy), .done(done), .dout(dout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] g;
        logic [7:0] d;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic       do_rst;
        logic       do_seed;
        logic [7:0] sd;
        int         who;
        logic [3:0] st;
        logic [7:0] exp_d;
    } vec_t;
    vec_t tbl[6];

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    endtask

    // Reference LFSR written on the q1..q8 register view.
    function automatic logic [7:0] ref_step(input logic [7:0] s);
        logic q[1:8];
        logic fb;
        logic [7:0] r;
        for (int k = 1; k <= 8; k++) q[k] = s[8-k];
        fb = q[8] ^ q[6] ^ q[5] ^ q[3];
        for (int k = 8; k >= 2; k--) q[k] = q[k-1];
        q[1] = fb;
        for (int k = 1; k <= 8; k++) r[8-k] = q[k];
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic seed_load(input logic [7:0] v);
        seed_we = 1'b1;
        seed    = v;
        @(posedge clk); #1;
        chk("seed_err_idle", 32'(seed_err), 32'(0));
        seed_we = 1'b0;
    endtask

    task automatic serve(input int who, input logic [3:0] st, input int inj_k, input logic [7:0] exp_d);
        int   k;
        int   bcnt;
        int   eff;
        sb_t  e;
        logic [1:0] g;
        g   = (who == 1) ? 2'b10 : 2'b01;
        eff = (st == 4'd0) ? 16 : int'(st);
        sb.push_back({g, exp_d});
        if (who == 1) begin req1 = 1'b1; steps1 = st; end
        else          begin req0 = 1'b1; steps0 = st; end
        @(posedge clk); #1;
        chk("grant_gnt", 32'(gnt), 32'(g));
        chk("grant_busy", 32'(busy), 32'(1));
        steps0 = ~st;
        steps1 = ~st;
        k = 0;
        bcnt = 1;
        while (!done && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (busy) bcnt++;
            if (inj_k > 0) begin
                if (k == inj_k) begin
                    seed_we = 1'b1;
                    seed    = 8'h55;
                end else if (k == inj_k + 1) begin
                    chk("seed_err_pulse", 32'(seed_err), 32'(1));
                    seed_we = 1'b0;
                end else if (k == inj_k + 2) begin
                    chk("seed_err_clear", 32'(seed_err), 32'(0));
                end
            end
        end
        chk("done_seen", 32'(done), 32'(1));
        chk("latency", 32'(k), 32'(eff));
        chk("busy_cycles", 32'(bcnt), 32'(eff + 1));
        e = sb.pop_front();
        chk("dout", 32'(dout), 32'(e.d));
        chk("done_gnt", 32'(gnt), 32'(e.g));
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clk); #1;
        chk("after_gnt", 32'(gnt), 32'(0));
        chk("after_busy", 32'(busy), 32'(0));
        chk("after_done", 32'(done), 32'(0));
        chk("dout_hold", 32'(dout), 32'(e.d));
    endtask

    initial begin
        int         k;
        int         seen;
        sb_t        e;
        logic [7:0] m;

        tbl[0] = '{1'b0, 1'b1, 8'h01, 0, 4'd1, 8'h80};
        tbl[1] = '{1'b1, 1'b0, 8'h00, 1, 4'd3, 8'h20};
        tbl[2] = '{1'b0, 1'b1, 8'h00, 0, 4'd1, 8'h80};
        tbl[3] = '{1'b0, 1'b0, 8'h00, 1, 4'd3, 8'h90};
        tbl[4] = '{1'b0, 1'b1, 8'h20, 1, 4'd2, 8'h48};
        tbl[5] = '{1'b0, 1'b1, 8'h48, 0, 4'd4, 8'h94};

        rst = 1'b1; seed_we = 1'b0; seed = 8'h00;
        req0 = 1'b0; req1 = 1'b0; steps0 = 4'd0; steps1 = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_dout", 32'(dout), 32'(0));
        chk("rst_seed_err", 32'(seed_err), 32'(0));
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].do_rst) do_reset();
            if (tbl[i].do_seed) seed_load(tbl[i].sd);
            serve(tbl[i].who, tbl[i].st, 0, tbl[i].exp_d);
        end

        // Ties alternate 0,1,0,1 while both requesters stay high.
        do_reset();
        m = 8'h01;
        for (int i = 0; i < 4; i++) begin
            m = ref_step(m);
            sb.push_back({(i % 2 == 1) ? 2'b10 : 2'b01, m});
        end
        req0 = 1'b1; req1 = 1'b1; steps0 = 4'd1; steps1 = 4'd1;
        for (int i = 0; i < 4; i++) begin
            k = 0;
            while (!done && k < 40) begin
                @(posedge clk); #1;
                k++;
            end
            chk("tie_done", 32'(done), 32'(1));
            e = sb.pop_front();
            chk("tie_gnt", 32'(gnt), 32'(e.g));
            chk("tie_dout", 32'(dout), 32'(e.d));
            @(posedge clk); #1;
            chk("tie_idle_gap", 32'(busy), 32'(0));
            if (i == 3) begin req0 = 1'b0; req1 = 1'b0; end
        end

        // Zero seed loads SEED_INIT; a seed write during RUN is rejected.
        seed_load(8'h00);
        serve(0, 4'd1, 0, 8'h80);
        seed_load(8'h00);
        serve(0, 4'd4, 1, 8'h90);

        // Reset in the middle of an 8-step service.
        req0 = 1'b1; steps0 = 4'd8;
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy), 32'(1));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1; req0 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_gnt", 32'(gnt), 32'(0));
        chk("abort_busy0", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'(0));
        serve(0, 4'd1, 0, 8'h80);

        // steps0 = 0 runs 16 steps from the current value 0x80.
        m = 8'h80;
        for (int i = 0; i < 16; i++) m = ref_step(m);
        serve(0, 4'd0, 0, m);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lfsr8_sched.md
Name: lfsr8_sched

Overview:
- Scheduler that shares one 8-bit Fibonacci LFSR between two requesters.
- Sequencing per grant: arbitrate, step the LFSR N times, return the resulting byte with a one-cycle done pulse.
- Also owns seed loading and all-zero lockup protection.
- Sits between the LFSR datapath and its random-byte consumers.

Parameters:
- SEED_INIT, 8'h01, LFSR value after reset; also substituted for any zero seed.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- seed_we  input  1  seed write strobe
- seed  input  8  seed value
- seed_err  output  1  one-cycle pulse: seed_we arrived outside IDLE
- req0  input  1  requester 0 wants a byte; held until its done
- steps0  input  4  steps for requester 0 (0 means 16)
- req1  input  1  requester 1 wants a byte
- steps1  input  4  steps for requester 1 (0 means 16)
- gnt  output  2  one-hot grant, gnt[i] = requester i being served
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle result-valid pulse
- dout  output  8  result byte; holds until the next done

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- LFSR state: bits q1..q8, with byte mapping {q1..q8} = [7:0] (q1 is the MSB).
- One LFSR step: fb = q8^q6^q5^q3; q1<=fb; qk<=q(k-1) for k=2..8.
- Examples: 0x01->0x80->0x40->0x20; 0x80->0x40.
- Reset values: state=IDLE, lfsr=SEED_INIT, last=1 (requester 0 wins first tie), gnt=0, busy=0, done=0, dout=0x00, seed_err=0, cnt=0.
- States: IDLE, RUN, DONE.
- IDLE, seed_we=1: next lfsr = (seed==0) ? SEED_INIT : seed; stay IDLE.
  - seed_we beats any request in the same cycle; the request is served next cycle because req is held.
- IDLE, seed_we=0, any req high:
  - Winner: if both requesters are high, the one != last; else the requester that is high.
  - Actions: gnt<=onehot(winner); cnt<=(steps==0 ? 16 : steps); busy<=1; ->RUN.
- RUN: each cycle lfsr steps and cnt decrements; on the cycle cnt==1 the final step occurs and the state goes to DONE.
  - RUN therefore lasts exactly N cycles.
- DONE, one cycle:
  - done=1, dout=lfsr (after N steps); gnt still asserted; last<=winner.
  - Then ->IDLE, with gnt=0 and busy=0.
- Latency: req sampled at edge E0 -> RUN from E0; done=1 in the cycle after edge E0+N.
  - Back-to-back: next grant decided in the following IDLE cycle, so at least one idle cycle separates services.
- Requester obligations:
  - Drop req in the cycle after its done, or it is re-eligible.
  - Round-robin still favours the other requester on a tie.
- Requester deasserting req during RUN: ignored; the service completes and done pulses.
- seed_we in RUN or DONE: ignored, lfsr unaffected; seed_err=1 for one cycle.
- The LFSR holds its value in IDLE and DONE; it never reaches all-zero.
- rst at any state: immediate return to reset values next edge.
  - No done for an aborted service; lfsr=SEED_INIT.
- steps inputs are sampled only at grant; later changes have no effect.

Test Plan:
- Seed then single step: after reset, seed_we with seed=0x01, then req0 with steps0=1.
  - gnt=01 from the next edge; done=1 two cycles after req is sampled; dout=0x80; gnt returns to 0 after DONE.
- Multi-step from reset seed: rst, then req1 with steps1=3 (lfsr=0x01).
  - RUN lasts 3 cycles; done with dout=0x20 and gnt=10.
- Tie arbitration: after reset, req0 and req1 high together, both steps=1, each dropped after its own done.
  - Requester 0 is served first (dout=0x80), then requester 1 (dout=0x40).
  - Repeated ties alternate 0,1,0,1.
- Zero seed and rejected seed: seed_we with seed=0x00 in IDLE loads 0x01; a following req0 with steps0=1 gives dout=0x80.
  - seed_we with seed=0x55 during RUN gives a seed_err pulse; dout is the unperturbed sequence value.
- Reset mid-operation: rst asserted mid-RUN with steps0=8.
  - Next edge: gnt=0, busy=0, no done pulse, lfsr=SEED_INIT.
  - A subsequent req0 with steps0=1 gives dout=0x80.
- Steps=0 means 16: req0 with steps0=0.
  - busy is high for 17 cycles; done on the 17th cycle after the grant edge; dout equals the 16-step successor of the seed, checked against a reference model.
